// File: rtl/oclib_bc_word_arbiter_pkg.sv
// Shared types for the BC word-channel arbiter.
package oclib_pkg;

   // Transaction phases: pick a requester, push its command, await the reply, hand it back.
   typedef enum logic [1:0] {
      StIdle   = 2'd0,
      StSend   = 2'd1,
      StWait   = 2'd2,
      StReturn = 2'd3
   } oclib_bc_word_arb_state_e;

   localparam logic [7:0] DropCountMax = 8'hFF;

endpackage

// File: rtl/oclib_bc_word_arbiter_if.sv
// Requester and converter-side word channels of the BC word arbiter.
// The slave modport is the arbiter's view; master is the surrounding clients and converter.
interface oclib_bc_word_arbiter_if #(
   parameter int unsigned NumReq    = 4,
   parameter int unsigned WordWidth = 64
);

   logic [NumReq-1:0][WordWidth-1:0] reqData;
   logic [NumReq-1:0]                reqValid;
   logic [NumReq-1:0]                reqReady;
   logic [WordWidth-1:0]             rspData;
   logic [NumReq-1:0]                rspValid;
   logic [NumReq-1:0]                rspReady;
   logic [WordWidth-1:0]             cmdOutData;
   logic                             cmdOutValid;
   logic                             cmdOutReady;
   logic [WordWidth-1:0]             rspInData;
   logic                             rspInValid;
   logic                             rspInReady;

   modport slave (
      input  reqData, reqValid, rspReady, cmdOutReady, rspInData, rspInValid,
      output reqReady, rspData, rspValid, cmdOutData, cmdOutValid, rspInReady
   );

   modport master (
      output reqData, reqValid, rspReady, cmdOutReady, rspInData, rspInValid,
      input  reqReady, rspData, rspValid, cmdOutData, cmdOutValid, rspInReady
   );

endinterface

// File: rtl/oclib_bc_word_arbiter_arb_rr.sv
// Combinational round-robin picker: first set request bit after lastGrant, wrapping.
module oclib_arb_rr #(
   parameter int unsigned NumReq = 4
) (
   input  logic [NumReq-1:0]         request,
   input  logic [$clog2(NumReq)-1:0] lastGrant,
   output logic [$clog2(NumReq)-1:0] winner,
   output logic                      hit
);

   localparam int unsigned GrantW = $clog2(NumReq);

   logic [GrantW-1:0] idx;

   // Scan lastGrant+1 .. lastGrant+NumReq; lastGrant itself is checked last.
   always_comb begin
      winner = '0;
      hit    = 1'b0;
      idx    = '0;
      for (int k = 1; k <= int'(NumReq); k++) begin
         idx = GrantW'((int'(lastGrant) + k) % int'(NumReq));
         if (!hit && request[idx]) begin
            hit    = 1'b1;
            winner = idx;
         end
      end
   end

endmodule

// File: rtl/oclib_bc_word_arbiter.sv
// Round-robin transaction arbiter sharing one BC word channel among NumReq clients.
// Optional WAIT timeout: define OCLIB_BC_WORD_ARBITER_TIMEOUT_EN.
module oclib_bc_word_arbiter
   import oclib_pkg::*;
#(
   parameter int unsigned NumReq        = 4,
   parameter int unsigned WordWidth     = 64,
   parameter int unsigned TimeoutCycles = 1024
) (
   input  logic                      clock,
   input  logic                      reset,
   oclib_bc_word_arbiter_if.slave    bus,
   output logic [$clog2(NumReq)-1:0] grant,
   output logic                      busy,
   output logic [7:0]                dropCount
);

   localparam int unsigned GrantW = $clog2(NumReq);

   oclib_bc_word_arb_state_e stateQ, stateD;
   logic [GrantW-1:0]        grantQ, lastGrantQ, winner;
   logic                     hit;
   logic [WordWidth-1:0]     rspRegQ;
   logic [7:0]               dropQ;
   logic                     rspAccept, retDone, stray, timeoutHit;

   oclib_arb_rr #(
      .NumReq (NumReq)
   ) uArbRr (
      .request   (bus.reqValid),
      .lastGrant (lastGrantQ),
      .winner    (winner),
      .hit       (hit)
   );

   assign rspAccept = (stateQ == StWait) && bus.rspInValid;
   assign retDone   = (stateQ == StReturn) && bus.rspReady[grantQ];
   // Outside WAIT every offered response word is swallowed and counted.
   assign stray     = (stateQ != StWait) && bus.rspInValid;

`ifdef OCLIB_BC_WORD_ARBITER_TIMEOUT_EN
   logic [31:0] waitCntQ;

   assign timeoutHit = (stateQ == StWait) && !bus.rspInValid &&
                       (waitCntQ == TimeoutCycles - 32'd1);

   // Count cycles spent in WAIT; cleared whenever WAIT is left or not occupied.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         waitCntQ <= '0;
      end else if ((stateQ == StWait) && (stateD == StWait)) begin
         waitCntQ <= waitCntQ + 32'd1;
      end else begin
         waitCntQ <= '0;
      end
   end
`else
   assign timeoutHit = 1'b0;
`endif

   // State register.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         stateQ <= StIdle;
      end else begin
         stateQ <= stateD;
      end
   end

   // Next-state logic.
   always_comb begin
      stateD = stateQ;
      unique case (stateQ)
         StIdle:   if (hit) stateD = StSend;
         StSend:   if (bus.cmdOutReady) stateD = StWait;
         StWait:   if (rspAccept || timeoutHit) stateD = StReturn;
         StReturn: if (retDone) stateD = StIdle;
         default:  stateD = StIdle;
      endcase
   end

   // Handshake outputs; only the granted requester ever sees a ready or valid.
   always_comb begin
      bus.reqReady    = '0;
      bus.rspValid    = '0;
      bus.cmdOutValid = 1'b0;
      bus.cmdOutData  = '0;
      // Held low while reset is asserted so every ready output reads 0 in reset.
      bus.rspInReady  = reset;
      busy            = (stateQ != StIdle);
      case (stateQ)
         StSend: begin
            bus.cmdOutValid      = 1'b1;
            bus.cmdOutData       = bus.reqData[grantQ];
            bus.reqReady[grantQ] = bus.cmdOutReady;
         end
         StReturn: bus.rspValid[grantQ] = 1'b1;
         default: ;
      endcase
   end

   // Grant bookkeeping: winner latched in IDLE, lastGrant advanced on delivery.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         grantQ     <= '0;
         lastGrantQ <= GrantW'(NumReq - 1);
      end else begin
         if ((stateQ == StIdle) && hit) grantQ <= winner;
         if (retDone) lastGrantQ <= grantQ;
      end
   end

   // Response register, loaded only in WAIT so rspData holds through RETURN.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         rspRegQ <= '0;
      end else if (rspAccept) begin
         rspRegQ <= bus.rspInData;
      end else if (timeoutHit) begin
         rspRegQ <= '1;
      end
   end

   // Saturating stray-response counter.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         dropQ <= '0;
      end else if (stray && (dropQ != DropCountMax)) begin
         dropQ <= dropQ + 8'd1;
      end
   end

   assign bus.rspData = rspRegQ;
   assign grant       = grantQ;
   assign dropCount   = dropQ;

endmodule

// File: tb/tb_oclib_bc_word_arbiter.sv
// Self-checking bench for oclib_bc_word_arbiter: transaction-level model plus directed scenarios.
module tb_oclib_bc_word_arbiter;

   localparam int unsigned NumReq        = 4;
   localparam int unsigned WordWidth     = 64;
   localparam int unsigned TimeoutCycles = 16;
   localparam logic [63:0] RspXor        = 64'hBB;

   logic       clock = 1'b0;
   logic       reset = 1'b0;
   logic [1:0] grant;
   logic       busy;
   logic [7:0] dropCount;

   oclib_bc_word_arbiter_if #(.NumReq(NumReq), .WordWidth(WordWidth)) bus ();

   oclib_bc_word_arbiter #(
      .NumReq        (NumReq),
      .WordWidth     (WordWidth),
      .TimeoutCycles (TimeoutCycles)
   ) dut (
      .clock     (clock),
      .reset     (reset),
      .bus       (bus),
      .grant     (grant),
      .busy      (busy),
      .dropCount (dropCount)
   );

   always #5 clock = ~clock;

   int checks = 0;
   int failures = 0;

   // Knobs written by the main sequence only.
   int wantCnt[NumReq];
   int cmdHoldReq, rspHoldReq, strayReq;
   bit convAuto;
   // Counters private to the driver.
   int issued[NumReq];
   int cmdHoldDone, rspHoldDone, strayDone;
   // Negedge snapshots written by the compare process.
   bit          sCmdAcc, sCmdVal, sRspVal;
   logic [63:0] sCmdData;
   bit          sReqAcc[NumReq];

   // Transaction-level model.
   bit          mHave, mSent, mGot;
   int          mReq, mLast, mGrant, mDrop, mWait;
   logic [63:0] mWord;
   logic [63:0] expQ[NumReq][$];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [63:0] dataOf(input int i, input int n);
      return 64'h11 + 64'(i) * 64'h100 + 64'(n) * 64'h10000;
   endfunction

   // Requesters and converter, driven just after each rising edge.
   always @(posedge clock) begin
      #1;
      if (!reset) begin
         for (int i = 0; i < NumReq; i++) issued[i] = 0;
         cmdHoldDone = 0; rspHoldDone = 0; strayDone = 0;
         bus.reqValid = '0; bus.reqData = '0; bus.rspReady = '0;
         bus.cmdOutReady = 1'b0; bus.rspInValid = 1'b0; bus.rspInData = '0;
      end else begin
         for (int i = 0; i < NumReq; i++) begin
            if (sReqAcc[i]) issued[i]++;
            bus.reqValid[i] = (issued[i] < wantCnt[i]);
            bus.reqData[i]  = dataOf(i, issued[i]);
         end
         if (sCmdVal && cmdHoldDone < cmdHoldReq) cmdHoldDone++;
         bus.cmdOutReady = (cmdHoldDone >= cmdHoldReq);
         if (sRspVal && rspHoldDone < rspHoldReq) rspHoldDone++;
         bus.rspReady = (rspHoldDone >= rspHoldReq) ? '1 : '0;
         bus.rspInValid = 1'b0;
         if (strayDone < strayReq) begin
            bus.rspInValid = 1'b1;
            bus.rspInData  = 64'hDEAD_0000 + 64'(strayDone);
            strayDone++;
         end else if (convAuto && sCmdAcc) begin
            bus.rspInValid = 1'b1;
            bus.rspInData  = sCmdData ^ RspXor;
         end
      end
   end

   // Compare process: every cycle, DUT outputs against the model, then advance the model.
   always @(negedge clock) begin
      if (!reset) begin
         mHave = 0; mSent = 0; mGot = 0; mReq = 0; mLast = NumReq - 1; mGrant = 0;
         mDrop = 0; mWait = 0; mWord = '0;
         sCmdAcc = 0; sCmdVal = 0; sRspVal = 0; sCmdData = '0;
         for (int i = 0; i < NumReq; i++) begin
            sReqAcc[i] = 0;
            expQ[i].delete();
         end
      end else begin
         logic [NumReq-1:0] eReqReady, eRspValid;
         eReqReady = '0;
         eRspValid = '0;
         if (mHave && !mSent) eReqReady[mReq] = bus.cmdOutReady;
         if (mHave && mGot) eRspValid[mReq] = 1'b1;
         check("busy", busy, mHave);
         check("grant", grant, mGrant);
         check("dropCount", dropCount, mDrop);
         check("cmdOutValid", bus.cmdOutValid, mHave && !mSent);
         if (mHave && !mSent) check("cmdOutData", bus.cmdOutData, bus.reqData[mReq]);
         check("reqReady", bus.reqReady, eReqReady);
         check("rspValid", bus.rspValid, eRspValid);
         check("rspData", bus.rspData, mWord);
         check("rspInReady", bus.rspInReady, 1'b1);

         sCmdVal  = bus.cmdOutValid;
         sCmdAcc  = bus.cmdOutValid && bus.cmdOutReady;
         sCmdData = bus.cmdOutData;
         sRspVal  = (bus.rspValid != '0);
         for (int i = 0; i < NumReq; i++) begin
            sReqAcc[i] = bus.reqValid[i] && bus.reqReady[i];
            if (sReqAcc[i] && convAuto) expQ[i].push_back(bus.reqData[i] ^ RspXor);
            if (bus.rspValid[i] && bus.rspReady[i] && expQ[i].size() > 0)
               check("ownResponse", bus.rspData, expQ[i].pop_front());
         end

         if (!mHave) begin
            if (bus.rspInValid && mDrop < 255) mDrop++;
            for (int k = 1; k <= NumReq; k++) begin
               int idx;
               idx = (mLast + k) % NumReq;
               if (!mHave && bus.reqValid[idx]) begin
                  mHave = 1; mSent = 0; mGot = 0; mWait = 0; mReq = idx; mGrant = idx;
               end
            end
         end else if (!mSent) begin
            if (bus.rspInValid && mDrop < 255) mDrop++;
            if (bus.cmdOutReady) mSent = 1;
         end else if (!mGot) begin
            if (bus.rspInValid) begin
               mGot = 1; mWord = bus.rspInData;
            end else begin
`ifdef OCLIB_BC_WORD_ARBITER_TIMEOUT_EN
               if (mWait == TimeoutCycles - 1) begin
                  mGot = 1; mWord = '1;
               end else begin
                  mWait++;
               end
`endif
            end
         end else begin
            if (bus.rspInValid && mDrop < 255) mDrop++;
            if (bus.rspReady[mReq]) begin
               mHave = 0; mLast = mReq;
            end
         end
      end
   end

   task automatic doReset();
      @(negedge clock);
      reset = 1'b0;
      for (int i = 0; i < NumReq; i++) wantCnt[i] = 0;
      cmdHoldReq = 0; rspHoldReq = 0; strayReq = 0; convAuto = 1'b0;
      @(negedge clock);
      #2 reset = 1'b1;
   endtask

   initial begin
      int busyCnt, rspCnt, rspK, nAcc, stallCnt, holdCnt, badGrant, changes, waitCyc, seen;
      int accGrant[5];
      int accCyc[5];
      int expSeq[5];
      logic [63:0] data0, lastRsp, lastCmd;
      expSeq = '{0, 1, 2, 3, 0};
      for (int i = 0; i < NumReq; i++) wantCnt[i] = 0;
      cmdHoldReq = 0; rspHoldReq = 0; strayReq = 0; convAuto = 1'b0;

      // Reset values.
      repeat (2) @(negedge clock);
      check("rst_busy", busy, 0);
      check("rst_grant", grant, 0);
      check("rst_drop", dropCount, 0);
      check("rst_cmdOutValid", bus.cmdOutValid, 0);
      check("rst_rspValid", bus.rspValid, 0);
      check("rst_reqReady", bus.reqReady, 0);
      check("rst_rspInReady", bus.rspInReady, 0);
      check("rst_rspData", bus.rspData, 0);
      #2 reset = 1'b1;

      // Single requester: 0x11 in, 0xAA back, four-cycle transaction.
      @(negedge clock);
      wantCnt[0] = 1; convAuto = 1'b1;
      busyCnt = 0; rspCnt = 0; rspK = -1; data0 = '0;
      for (int k = 0; k < 8; k++) begin
         @(negedge clock);
         if (busy) busyCnt++;
         if (bus.rspValid[0]) begin
            rspCnt++;
            if (rspK < 0) begin rspK = k; data0 = bus.rspData; end
         end
      end
      check("single_rspCycles", rspCnt, 1);
      check("single_rspLatency", rspK, 3);
      check("single_rspData", data0, 64'hAA);
      check("single_busyCycles", busyCnt, 3);
      check("single_grant", grant, 0);

      // Contention: grant order 0,1,2,3,0, one command every 4 cycles.
      doReset();
      wantCnt[0] = 2; wantCnt[1] = 1; wantCnt[2] = 1; wantCnt[3] = 1; convAuto = 1'b1;
      nAcc = 0;
      for (int k = 0; k < 60 && nAcc < 5; k++) begin
         @(negedge clock);
         if (bus.cmdOutValid && bus.cmdOutReady) begin
            accGrant[nAcc] = grant; accCyc[nAcc] = k; nAcc++;
         end
      end
      check("contention_count", nAcc, 5);
      for (int i = 0; i < nAcc; i++) check("contention_grant", accGrant[i], expSeq[i]);
      if (nAcc >= 2) check("contention_spacing", accCyc[1] - accCyc[0], 4);

      // Backpressure: 5 stalled SEND cycles, 3 stalled RETURN cycles, grant pinned to 0.
      doReset();
      cmdHoldReq = 5; rspHoldReq = 3; wantCnt[0] = 1; wantCnt[1] = 1; convAuto = 1'b1;
      stallCnt = 0; holdCnt = 0; badGrant = 0; changes = 0; seen = 0;
      lastRsp = '0; lastCmd = '0;
      for (int k = 0; k < 30 && seen == 0; k++) begin
         @(negedge clock);
         if (busy && grant != 0) badGrant++;
         if (bus.cmdOutValid) begin
            if (stallCnt > 0 && bus.cmdOutData !== lastCmd) changes++;
            lastCmd = bus.cmdOutData;
            if (!bus.cmdOutReady) stallCnt++;
         end
         if (bus.rspValid != '0) begin
            if (holdCnt > 0 && bus.rspData !== lastRsp) changes++;
            lastRsp = bus.rspData;
            if (!bus.rspReady[grant]) holdCnt++;
            else seen = 1;
         end
      end
      check("bp_done", seen, 1);
      check("bp_sendStall", stallCnt, 5);
      check("bp_returnStall", holdCnt, 3);
      check("bp_otherGrant", badGrant, 0);
      check("bp_dataStable", changes, 0);

      // Stray responses in IDLE, then a normal transaction, then saturation.
      doReset();
      strayReq = 3;
      repeat (8) @(negedge clock);
      check("stray_three", dropCount, 3);
      wantCnt[0] = 1; convAuto = 1'b1; seen = 0;
      for (int k = 0; k < 12 && seen == 0; k++) begin
         @(negedge clock);
         if (bus.rspValid[0] && bus.rspReady[0]) seen = 1;
      end
      check("stray_txnDone", seen, 1);
      check("stray_afterTxn", dropCount, 3);
      strayReq = 303;
      repeat (310) @(negedge clock);
      check("stray_saturate", dropCount, 255);

      // Silent converter.
      doReset();
      wantCnt[2] = 1;
`ifdef OCLIB_BC_WORD_ARBITER_TIMEOUT_EN
      waitCyc = 0; seen = 0; data0 = '0;
      for (int k = 0; k < 40 && seen == 0; k++) begin
         @(negedge clock);
         if (busy && !bus.cmdOutValid && bus.rspValid == '0) waitCyc++;
         if (bus.rspValid[2]) begin seen = 1; data0 = bus.rspData; end
      end
      check("to_seen", seen, 1);
      check("to_waitCycles", waitCyc, 16);
      check("to_errorWord", data0, 64'hFFFF_FFFF_FFFF_FFFF);
      strayReq = 1;
      repeat (4) @(negedge clock);
      check("to_lateDrop", dropCount, 1);
`else
      rspCnt = 0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clock);
         if (bus.rspValid != '0) rspCnt++;
      end
      check("wait_noRsp", rspCnt, 0);
      check("wait_busy", busy, 1);
      strayReq = 1; seen = 0;
      for (int k = 0; k < 6 && seen == 0; k++) begin
         @(negedge clock);
         if (bus.rspValid[2]) begin seen = 1; data0 = bus.rspData; end
      end
      check("wait_lateRsp", data0, 64'hDEAD_0000);
      check("wait_noDrop", dropCount, 0);
`endif

      // Reset asserted mid-WAIT.
      doReset();
      strayReq = 2;
      repeat (4) @(negedge clock);
      wantCnt[1] = 1; seen = 0;
      for (int k = 0; k < 10 && seen == 0; k++) begin
         @(negedge clock);
         if (busy && !bus.cmdOutValid && bus.rspValid == '0) seen = 1;
      end
      check("mid_inWait", seen, 1);
      check("mid_preGrant", grant, 1);
      check("mid_preDrop", dropCount, 2);
      #2 reset = 1'b0;
      #1;
      check("mid_busy", busy, 0);
      check("mid_grant", grant, 0);
      check("mid_drop", dropCount, 0);
      check("mid_rspValid", bus.rspValid, 0);
      check("mid_cmdOutValid", bus.cmdOutValid, 0);
      check("mid_rspInReady", bus.rspInReady, 0);
      for (int i = 0; i < NumReq; i++) wantCnt[i] = 0;
      strayReq = 0;
      @(negedge clock);
      #2 reset = 1'b1;
      wantCnt[0] = 1; wantCnt[1] = 1; convAuto = 1'b1; seen = 0;
      for (int k = 0; k < 10 && seen == 0; k++) begin
         @(negedge clock);
         if (bus.cmdOutValid && bus.cmdOutReady) begin
            seen = 1;
            check("mid_firstWinner", grant, 0);
         end
      end
      check("mid_reissued", seen, 1);

      repeat (12) @(negedge clock);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/oclib_bc_word_arbiter.md
# oclib_bc_word_arbiter

Round-robin transaction arbiter that shares one bidirectional BC word channel among several requesters. It sits between N command/response clients and the word side of a BC bidi-to-words converter. Each transaction is one command word followed by one response word. The grant is held from command issue until the matching response is delivered back to the same requester.

## Interface
- NumReq, 4: number of requesters, 2..16
- WordWidth, 64: command and response word width
- TimeoutCycles, 1024: cycles spent in WAIT before the transaction is aborted; used only with the timeout feature
- clock  in  1  single clock
- reset  in  1  asynchronous, active-low reset
- reqData  in  NumReq×WordWidth  per-requester command word
- reqValid  in  NumReq  per-requester command valid
- reqReady  out  NumReq  per-requester command accept
- rspData  out  WordWidth  response word, shared by all requesters
- rspValid  out  NumReq  per-requester response valid; one-hot or zero
- rspReady  in  NumReq  per-requester response accept
- cmdOutData  out  WordWidth  command word to the converter's word input
- cmdOutValid  out  1  command valid to the converter
- cmdOutReady  in  1  converter accepts the command
- rspInData  in  WordWidth  response word from the converter's word output
- rspInValid  in  1  converter response valid
- rspInReady  out  1  response accept to the converter
- grant  out  $clog2(NumReq)  index of the current or last granted requester
- busy  out  1  high in any state other than IDLE
- dropCount  out  8  saturating count of discarded response words

## Operation
- The FSM has four states: IDLE, SEND, WAIT, RETURN.
- IDLE:
  - Round-robin search of reqValid, starting at lastGrant+1 and wrapping modulo NumReq.
  - On a hit, register the winner in grant and move to SEND.
  - No reqReady is asserted in IDLE.
- SEND:
  - cmdOutValid=1 and cmdOutData=reqData[grant].
  - reqReady[grant]=cmdOutReady, passed through combinationally.
  - On cmdOutReady, move to WAIT.
  - reqValid must stay high while in SEND; dropping it is a protocol violation and is not checked.
- WAIT:
  - rspInReady=1.
  - On rspInValid, capture rspInData into the response register and move to RETURN.
- RETURN:
  - rspValid[grant]=1 and rspData=the response register.
  - On rspReady[grant], set lastGrant=grant and move to IDLE.
- Stray responses: in IDLE, SEND and RETURN, rspInReady=1. Any rspInValid word in these states is discarded and increments dropCount, which saturates at 255.
- Only the granted requester ever sees reqReady or rspValid. All other bits are 0.
- Requests arriving mid-transaction wait. Fairness guarantee: each valid requester is served within NumReq transactions.

## Timing
- Reset values:
  - FSM=IDLE, grant=0, lastGrant=NumReq-1 (so requester 0 wins first).
  - dropCount=0, response register=0.
  - All valid and ready outputs are 0, and busy=0.
- Minimum transaction is 4 cycles: IDLE→SEND→WAIT→RETURN→IDLE, with cmdOutReady, rspInValid and rspReady all high.
- Back-to-back transactions therefore issue every 4 cycles.
- Arbitration latency: reqValid seen in IDLE gives cmdOutValid on the next cycle.
- The response register is loaded only in WAIT. rspData is stable for the whole of RETURN.
- If rspInValid is high in the same cycle that SEND completes, that word is counted as a drop; the FSM is not yet in WAIT.
- Reset asserted mid-transaction returns the block to reset values immediately. Any in-flight command or response is lost, and requesters must reissue.

## Configuration
- Macro: OCLIB_BC_WORD_ARBITER_TIMEOUT_EN.
- Defined:
  - A 32-bit wait counter runs in WAIT.
  - When the counter reaches TimeoutCycles-1 with no rspInValid, the response register is loaded with all ones and the FSM moves to RETURN.
  - The error word is delivered to the granted requester like a normal response.
  - A response arriving later is handled as a stray and counted in dropCount.
  - The counter clears on leaving WAIT.
- Not defined:
  - WAIT has no timeout and lasts indefinitely.
  - The TimeoutCycles parameter is ignored.

## Structure
- oclib_pkg holds the state enum type oclib_bc_word_arb_state_e (IDLE, SEND, WAIT, RETURN).
- Sub-module oclib_arb_rr: a combinational round-robin picker.
  - Inputs: request vector and lastGrant.
  - Outputs: winner index and a hit flag.
  - Also reusable by other arbiters.
- The top level contains the FSM, the response register and the counters.

## Test plan
- Single requester: reqValid[0]=1 with data 0x11, converter returns 0xAA → rspValid[0] for one cycle with rspData=0xAA; total 4 cycles; grant=0.
- Contention: all 4 requesters valid from reset → grant sequence is 0,1,2,3,0; each requester receives only its own response.
- Backpressure: hold cmdOutReady=0 for 5 cycles, then hold rspReady[grant]=0 for 3 cycles → block stays in SEND, then in RETURN, with data stable; no other requester is granted.
- Stray response: rspInValid pulsed 3 times while in IDLE → dropCount=3; the next transaction completes normally. Then inject 300 stray words → dropCount saturates at 255.
- Timeout (macro defined, TimeoutCycles=16): converter never responds → after 16 WAIT cycles the requester gets rspData=all ones; a late response then increments dropCount.
- Reset asserted mid-WAIT → all outputs return to reset values within the same cycle; after reset release, requester 0 wins first.
